// File: rtl/trail_board_ctrl.sv
// trail_board_ctrl: serialises two players' plot requests, checks them against a 1-bit occupancy map and drives the vga_adapter.
// Define BORDER_EN to draw a collidable border during every clear sweep.
module trail_board_ctrl #(
    parameter int         W         = 160,
    parameter int         H         = 120,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter logic [2:0] BD_COLOUR = 3'b111,
    parameter int         BX0       = 10,
    parameter int         BX1       = 149,
    parameter int         BY0       = 17,
    parameter int         BY1       = 108
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       clear_req,
    input  logic       p1_valid,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [2:0] p1_colour,
    output logic       p1_ready,
    output logic       p1_hit,
    output logic       p1_dead,
    input  logic       p2_valid,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    input  logic [2:0] p2_colour,
    output logic       p2_ready,
    output logic       p2_hit,
    output logic       p2_dead,
    output logic       busy,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam int          CELLS     = W * H;
    localparam logic [14:0] LAST_ADDR = 15'(CELLS - 1);
    localparam logic [14:0] W15       = 15'(W);
    localparam logic [7:0]  X_MAX     = 8'(W - 1);
    localparam logic [6:0]  Y_MAX     = 7'(H - 1);
    localparam logic [7:0]  BX0_L     = 8'(BX0);
    localparam logic [7:0]  BX1_L     = 8'(BX1);
    localparam logic [6:0]  BY0_L     = 7'(BY0);
    localparam logic [6:0]  BY1_L     = 7'(BY1);
`ifdef BORDER_EN
    localparam logic BORDER_ON = 1'b1;
`else
    localparam logic BORDER_ON = 1'b0;
`endif

    typedef enum logic [1:0] {CLEAR, IDLE, READ, COMMIT} state_t;

    state_t      state, state_nx;
    logic [7:0]  clr_x, clr_x_nx;
    logic [6:0]  clr_y, clr_y_nx;
    logic [14:0] clr_addr, clr_addr_nx;
    logic [7:0]  req_x, req_x_nx;
    logic [6:0]  req_y, req_y_nx;
    logic [2:0]  req_colour, req_colour_nx;
    logic [14:0] req_addr, req_addr_nx;
    logic        req_p2, req_p2_nx;
    logic        req_off, req_off_nx;
    logic        req_dead, req_dead_nx;
    logic        last_p2, last_p2_nx;
    logic        p1_ready_nx, p2_ready_nx, p1_hit_nx, p2_hit_nx;
    logic        p1_dead_nx, p2_dead_nx, vga_plot_nx;
    logic [7:0]  vga_x_nx;
    logic [6:0]  vga_y_nx;
    logic [2:0]  vga_colour_nx;

    logic        map_mem [CELLS];
    logic [14:0] map_addr;
    logic        map_we, map_wdata, rd_bit;

    logic        grant_p1, grant_p2;
    logic [7:0]  sel_x;
    logic [6:0]  sel_y;
    logic [2:0]  sel_colour;
    logic        clr_border, clr_bit;

    assign busy = (state == CLEAR);

    // The last-served player loses a tie; last_p2 resets high so p1 wins the first one.
    assign grant_p1   = p1_valid && (!p2_valid || last_p2);
    assign grant_p2   = p2_valid && !grant_p1;
    assign sel_x      = grant_p2 ? p2_x : p1_x;
    assign sel_y      = grant_p2 ? p2_y : p1_y;
    assign sel_colour = grant_p2 ? p2_colour : p1_colour;

    assign clr_border = ((clr_y == BY0_L || clr_y == BY1_L) && clr_x >= BX0_L && clr_x <= BX1_L) ||
                        ((clr_x == BX0_L || clr_x == BX1_L) && clr_y >= BY0_L && clr_y <= BY1_L);
    assign clr_bit    = BORDER_ON & clr_border;
    assign map_addr   = (state == CLEAR) ? clr_addr : req_addr;

    always_ff @(posedge CLOCK_50) begin
        if (map_we)
            map_mem[map_addr] <= map_wdata;
        rd_bit <= map_mem[map_addr];
    end

    always_comb begin
        state_nx      = state;
        clr_x_nx      = clr_x;
        clr_y_nx      = clr_y;
        clr_addr_nx   = clr_addr;
        req_x_nx      = req_x;
        req_y_nx      = req_y;
        req_colour_nx = req_colour;
        req_addr_nx   = req_addr;
        req_p2_nx     = req_p2;
        req_off_nx    = req_off;
        req_dead_nx   = req_dead;
        last_p2_nx    = last_p2;
        p1_dead_nx    = p1_dead;
        p2_dead_nx    = p2_dead;
        p1_ready_nx   = 1'b0;
        p2_ready_nx   = 1'b0;
        p1_hit_nx     = 1'b0;
        p2_hit_nx     = 1'b0;
        vga_plot_nx   = 1'b0;
        vga_x_nx      = vga_x;
        vga_y_nx      = vga_y;
        vga_colour_nx = vga_colour;
        map_we        = 1'b0;
        map_wdata     = 1'b0;

        case (state)
            CLEAR: begin
                map_we        = 1'b1;
                map_wdata     = clr_bit;
                vga_plot_nx   = 1'b1;
                vga_x_nx      = clr_x;
                vga_y_nx      = clr_y;
                vga_colour_nx = clr_bit ? BD_COLOUR : BG_COLOUR;
                p1_dead_nx    = 1'b0;
                p2_dead_nx    = 1'b0;
                if (clr_addr == LAST_ADDR) begin
                    state_nx    = IDLE;
                    clr_x_nx    = '0;
                    clr_y_nx    = '0;
                    clr_addr_nx = '0;
                end else begin
                    clr_addr_nx = clr_addr + 15'd1;
                    if (clr_x == X_MAX) begin
                        clr_x_nx = '0;
                        clr_y_nx = clr_y + 7'd1;
                    end else begin
                        clr_x_nx = clr_x + 8'd1;
                    end
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_nx    = CLEAR;
                    clr_x_nx    = '0;
                    clr_y_nx    = '0;
                    clr_addr_nx = '0;
                end else if (grant_p1 || grant_p2) begin
                    state_nx      = READ;
                    p1_ready_nx   = grant_p1;
                    p2_ready_nx   = grant_p2;
                    last_p2_nx    = grant_p2;
                    req_p2_nx     = grant_p2;
                    req_x_nx      = sel_x;
                    req_y_nx      = sel_y;
                    req_colour_nx = sel_colour;
                    req_addr_nx   = 15'(sel_y) * W15 + 15'(sel_x);
                    req_off_nx    = (sel_x > X_MAX) || (sel_y > Y_MAX);
                    req_dead_nx   = grant_p2 ? p2_dead : p1_dead;
                end
            end
            READ: begin
                // map read for on-board requests is issued here through map_addr
                if (req_dead) begin
                    state_nx = IDLE;
                end else if (req_off) begin
                    state_nx   = IDLE;
                    p1_hit_nx  = !req_p2;
                    p2_hit_nx  = req_p2;
                    p1_dead_nx = p1_dead | !req_p2;
                    p2_dead_nx = p2_dead | req_p2;
                end else begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                state_nx = IDLE;
                if (rd_bit) begin
                    p1_hit_nx  = !req_p2;
                    p2_hit_nx  = req_p2;
                    p1_dead_nx = p1_dead | !req_p2;
                    p2_dead_nx = p2_dead | req_p2;
                end else begin
                    map_we        = 1'b1;
                    map_wdata     = 1'b1;
                    vga_plot_nx   = 1'b1;
                    vga_x_nx      = req_x;
                    vga_y_nx      = req_y;
                    vga_colour_nx = req_colour;
                end
            end
            default: state_nx = CLEAR;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= CLEAR;
            clr_x      <= '0;
            clr_y      <= '0;
            clr_addr   <= '0;
            req_x      <= '0;
            req_y      <= '0;
            req_colour <= '0;
            req_addr   <= '0;
            req_p2     <= 1'b0;
            req_off    <= 1'b0;
            req_dead   <= 1'b0;
            last_p2    <= 1'b1;
            p1_ready   <= 1'b0;
            p2_ready   <= 1'b0;
            p1_hit     <= 1'b0;
            p2_hit     <= 1'b0;
            p1_dead    <= 1'b0;
            p2_dead    <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state      <= state_nx;
            clr_x      <= clr_x_nx;
            clr_y      <= clr_y_nx;
            clr_addr   <= clr_addr_nx;
            req_x      <= req_x_nx;
            req_y      <= req_y_nx;
            req_colour <= req_colour_nx;
            req_addr   <= req_addr_nx;
            req_p2     <= req_p2_nx;
            req_off    <= req_off_nx;
            req_dead   <= req_dead_nx;
            last_p2    <= last_p2_nx;
            p1_ready   <= p1_ready_nx;
            p2_ready   <= p2_ready_nx;
            p1_hit     <= p1_hit_nx;
            p2_hit     <= p2_hit_nx;
            p1_dead    <= p1_dead_nx;
            p2_dead    <= p2_dead_nx;
            vga_plot   <= vga_plot_nx;
            vga_x      <= vga_x_nx;
            vga_y      <= vga_y_nx;
            vga_colour <= vga_colour_nx;
        end
    end

endmodule

// File: tb/tb_trail_board_ctrl.sv
// tb_trail_board_ctrl: table-driven requests with a plot scoreboard for trail_board_ctrl.
// Honours BORDER_EN the same way the design does.
module tb_trail_board_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       resetn, clear_req;
    logic       p1_valid, p2_valid;
    logic [7:0] p1_x, p2_x;
    logic [6:0] p1_y, p2_y;
    logic [2:0] p1_colour, p2_colour;
    logic       p1_ready, p1_hit, p1_dead, p2_ready, p2_hit, p2_dead;
    logic       busy, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    trail_board_ctrl dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .clear_req(clear_req),
        .p1_valid(p1_valid), .p1_x(p1_x), .p1_y(p1_y), .p1_colour(p1_colour),
        .p1_ready(p1_ready), .p1_hit(p1_hit), .p1_dead(p1_dead),
        .p2_valid(p2_valid), .p2_x(p2_x), .p2_y(p2_y), .p2_colour(p2_colour),
        .p2_ready(p2_ready), .p2_hit(p2_hit), .p2_dead(p2_dead),
        .busy(busy), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int         player;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        int         exp_hit;
        int         exp_plot;
        int         exp_dead;
    } vec_t;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        int         cyc;
    } plot_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    p1_hits = 0;
    int    p2_hits = 0;
    bit    clear_mode = 1'b0;
    int    clear_start = 0;
    int    clear_plots = 0;
    int    clear_bad = 0;
    int    mon_idx;
    plot_t mon_p;
    plot_t sb[$];
    vec_t  vecs[0:10];

    function automatic bit is_border(int x, int y);
`ifdef BORDER_EN
        return ((y == 17 || y == 108) && x >= 10 && x <= 149) ||
               ((x == 10 || x == 149) && y >= 17 && y <= 108);
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Hit counters and the plot scoreboard; clear sweeps are checked pixel by pixel against the raster order.
    always @(negedge CLOCK_50) begin
        if (p1_hit === 1'b1) p1_hits++;
        if (p2_hit === 1'b1) p2_hits++;
        if (resetn === 1'b1 && vga_plot === 1'b1) begin
            if (clear_mode) begin
                mon_idx = clear_plots - clear_start;
                if (mon_idx >= 19200 || int'(vga_x) != mon_idx % 160 || int'(vga_y) != mon_idx / 160 ||
                    int'(vga_colour) != (is_border(mon_idx % 160, mon_idx / 160) ? 7 : 0))
                    clear_bad++;
                clear_plots++;
            end else if (sb.size() == 0) begin
                checkOutput("unexpected_plot", {vga_x, vga_y, vga_colour}, -1);
            end else begin
                mon_p = sb.pop_front();
                checkOutput("plot_xyc", {vga_x, vga_y, vga_colour}, {mon_p.x, mon_p.y, mon_p.colour});
                checkOutput("plot_latency", cyc, mon_p.cyc);
            end
        end
    end

    task automatic waitReady(output int who);
        who = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (p1_ready && p2_ready) begin who = 3; return; end
            if (p1_ready) begin who = 1; return; end
            if (p2_ready) begin who = 2; return; end
        end
    endtask

    task automatic drive(input int player, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        if (player == 1) begin
            p1_valid = 1'b1; p1_x = x; p1_y = y; p1_colour = c;
        end else begin
            p2_valid = 1'b1; p2_x = x; p2_y = y; p2_colour = c;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int who, h;
        h = (v.player == 1) ? p1_hits : p2_hits;
        drive(v.player, v.x, v.y, v.colour);
        waitReady(who);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        checkOutput($sformatf("v%0d_ready", idx), who, v.player);
        if (who == v.player && v.exp_plot != 0)
            sb.push_back('{v.x, v.y, v.colour, cyc + 2});
        repeat (4) @(negedge CLOCK_50);
        checkOutput($sformatf("v%0d_hit", idx), ((v.player == 1) ? p1_hits : p2_hits) - h, v.exp_hit);
        checkOutput($sformatf("v%0d_dead", idx), int'((v.player == 1) ? p1_dead : p2_dead), v.exp_dead);
        checkOutput($sformatf("v%0d_sb_drained", idx), sb.size(), 0);
    endtask

    // Runs a full sweep, either from reset or from clear_req with a competing p1 request.
    task automatic runClear(input bit from_reset, input string tag);
        int n, bad0, d1, d2;
        d1 = 1; d2 = 1;
        if (from_reset) begin
            resetn = 1'b0;
            @(negedge CLOCK_50);
            checkOutput({tag, "_rst_busy"}, busy, 1);
            checkOutput({tag, "_rst_plot"}, vga_plot, 0);
            checkOutput({tag, "_rst_ready"}, {p1_ready, p2_ready}, 0);
            checkOutput({tag, "_rst_hitdead"}, {p1_hit, p2_hit, p1_dead, p2_dead}, 0);
            checkOutput({tag, "_rst_vga"}, {vga_x, vga_y, vga_colour}, 0);
            resetn = 1'b1;
        end else begin
            clear_req = 1'b1;
            drive(1, 8'd1, 7'd1, 3'd7);
            @(negedge CLOCK_50);
            clear_req = 1'b0;
            p1_valid = 1'b0;
            checkOutput({tag, "_clear_prio_ready"}, p1_ready, 0);
        end
        clear_start = clear_plots;
        bad0 = clear_bad;
        clear_mode = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            if (n == 2) begin d1 = p1_dead; d2 = p2_dead; end
            checkOutput({tag, "_busy_ready"}, 0, {p1_ready, p2_ready});
            if ({p1_ready, p2_ready} != 0) break;
            @(negedge CLOCK_50);
        end
        @(negedge CLOCK_50);
        clear_mode = 1'b0;
        checkOutput({tag, "_busy_cycles"}, n, 19200);
        checkOutput({tag, "_clear_plots"}, clear_plots - clear_start, 19200);
        checkOutput({tag, "_clear_bad_pixels"}, clear_bad - bad0, 0);
        checkOutput({tag, "_dead_cleared"}, {d1[0], d2[0]}, 0);
    endtask

    initial begin
        int who, h1, h2;
        resetn = 1'b0; clear_req = 1'b0;
        p1_valid = 1'b0; p1_x = '0; p1_y = '0; p1_colour = '0;
        p2_valid = 1'b0; p2_x = '0; p2_y = '0; p2_colour = '0;

        vecs[0]  = '{1, 8'd80,  7'd80,  3'b011, 0, 1, 0};
        vecs[1]  = '{1, 8'd25,  7'd100, 3'b001, 0, 1, 0};
        vecs[2]  = '{1, 8'd25,  7'd100, 3'b001, 1, 0, 1};
        vecs[3]  = '{1, 8'd30,  7'd30,  3'b001, 0, 0, 1};
        vecs[4]  = '{2, 8'd160, 7'd10,  3'b010, 1, 0, 1};
        vecs[5]  = '{1, 8'd0,   7'd0,   3'b010, 0, 1, 0};
        vecs[6]  = '{1, 8'd159, 7'd119, 3'b011, 0, 1, 0};
        vecs[7]  = '{1, 8'd25,  7'd100, 3'b001, 0, 1, 0};
`ifdef BORDER_EN
        vecs[8]  = '{1, 8'd10,  7'd60,  3'b100, 1, 0, 1};
        vecs[9]  = '{1, 8'd5,   7'd120, 3'b110, 0, 0, 1};
`else
        vecs[8]  = '{1, 8'd10,  7'd60,  3'b100, 0, 1, 0};
        vecs[9]  = '{1, 8'd5,   7'd120, 3'b110, 1, 0, 1};
`endif
        vecs[10] = '{2, 8'd40,  7'd40,  3'b101, 0, 0, 1};

        runClear(1'b1, "reset");

        // Simultaneous requests for one cell: p1 wins the first tie and claims it, p2 collides.
        h1 = p1_hits; h2 = p2_hits;
        drive(1, 8'd50, 7'd50, 3'b101);
        drive(2, 8'd50, 7'd50, 3'b110);
        waitReady(who);
        checkOutput("tie1_first", who, 1);
        if (who == 1) begin
            p1_valid = 1'b0;
            sb.push_back('{8'd50, 7'd50, 3'b101, cyc + 2});
        end
        waitReady(who);
        checkOutput("tie1_second", who, 2);
        p1_valid = 1'b0; p2_valid = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checkOutput("tie1_p1_hits", p1_hits - h1, 0);
        checkOutput("tie1_p2_hits", p2_hits - h2, 1);
        checkOutput("tie1_dead", {p1_dead, p2_dead}, 1);
        checkOutput("tie1_sb_drained", sb.size(), 0);

        applyStimulus(vecs[0], 0);

        // p1 was served last, so this tie goes to p2 (dead, discarded) before p1.
        h2 = p2_hits;
        drive(1, 8'd70, 7'd70, 3'b001);
        drive(2, 8'd71, 7'd71, 3'b010);
        waitReady(who);
        checkOutput("tie2_first", who, 2);
        if (who == 2) p2_valid = 1'b0;
        waitReady(who);
        checkOutput("tie2_second", who, 1);
        if (who == 1) sb.push_back('{8'd70, 7'd70, 3'b001, cyc + 2});
        p1_valid = 1'b0; p2_valid = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        checkOutput("tie2_p2_hits", p2_hits - h2, 0);
        checkOutput("tie2_sb_drained", sb.size(), 0);

        for (int i = 1; i <= 3; i++) applyStimulus(vecs[i], i);

        runClear(1'b0, "creq");

        for (int i = 4; i <= 10; i++) applyStimulus(vecs[i], i);

        repeat (5) @(negedge CLOCK_50);
        checkOutput("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
